// File: rtl/ctrl_fsm.sv
// Instruction register and Moore sequencer driving the datapath and register-file strobes.
// Optional build macro CTRL_ILLEGAL_TRAP_EN: illegal instructions lock into a TRAP state with err=1.
module ctrl_fsm (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] instr,
   input  logic        s,
   output logic        w,
   output logic [2:0]  readnum,
   output logic [2:0]  writenum,
   output logic        write,
   output logic        vsel,
   output logic        loada,
   output logic        loadb,
   output logic        asel,
   output logic        bsel,
   output logic        loadc,
   output logic        loads,
   output logic [1:0]  shift,
   output logic [1:0]  ALUop,
   output logic [15:0] sximm8,
   output logic [15:0] sximm5,
   output logic        err
);

   typedef enum logic [2:0] {
      S_WAIT, S_DECODE, S_WRITE_IMM, S_GET_A, S_GET_B, S_ALU, S_WRITE_REG, S_TRAP
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] ir_q, ir_d;

   logic [2:0] opcode, rn, rd, rm;
   logic [1:0] op;
   logic       is_movi, is_movr, is_arith, is_cmp, is_mvn;

   assign opcode   = ir_q[15:13];
   assign op       = ir_q[12:11];
   assign rn       = ir_q[10:8];
   assign rd       = ir_q[7:5];
   assign rm       = ir_q[2:0];
   assign is_movi  = (opcode == 3'b110) && (op == 2'b10);
   assign is_movr  = (opcode == 3'b110) && (op == 2'b00);
   assign is_arith = (opcode == 3'b101);
   assign is_cmp   = is_arith && (op == 2'b01);
   assign is_mvn   = is_arith && (op == 2'b11);

   assign shift  = ir_q[4:3];
   assign ALUop  = ir_q[12:11];
   assign sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};
   assign sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};

   // IR only accepts a new word while idle, so fields are stable for the whole instruction.
   assign ir_d = (load && (state_q == S_WAIT)) ? instr : ir_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_WAIT;
         ir_q    <= 16'h0000;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_WAIT:      if (s) state_d = S_DECODE;
         S_DECODE: begin
            if (is_movi)                 state_d = S_WRITE_IMM;
            else if (is_movr || is_mvn)  state_d = S_GET_B;
            else if (is_arith)           state_d = S_GET_A;
            else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
               state_d = S_TRAP;
`else
               state_d = S_WAIT;
`endif
            end
         end
         S_WRITE_IMM: state_d = S_WAIT;
         S_GET_A:     state_d = S_GET_B;
         S_GET_B:     state_d = S_ALU;
         S_ALU:       state_d = is_cmp ? S_WAIT : S_WRITE_REG;
         S_WRITE_REG: state_d = S_WAIT;
         S_TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            state_d = S_WAIT;
`endif
         end
         default:     state_d = S_WAIT;
      endcase
   end

   always_comb begin
      w        = (state_q == S_WAIT);
      readnum  = 3'd0;
      writenum = 3'd0;
      write    = 1'b0;
      vsel     = 1'b0;
      loada    = 1'b0;
      loadb    = 1'b0;
      asel     = 1'b0;
      bsel     = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      err      = (state_q == S_TRAP);
`else
      err      = 1'b0;
`endif
      case (state_q)
         S_WRITE_IMM: begin
            writenum = rn;
            vsel     = 1'b1;
            write    = 1'b1;
         end
         S_GET_A: begin
            readnum = rn;
            loada   = 1'b1;
         end
         S_GET_B: begin
            readnum = rm;
            loadb   = 1'b1;
         end
         S_ALU: begin
            // MOV reg passes B through the adder, so A is forced to zero.
            asel  = is_movr;
            loads = is_cmp;
            loadc = !is_cmp;
         end
         S_WRITE_REG: begin
            writenum = rd;
            write    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: directed vector table, corner-case sequences and
// randomized instructions checked against a per-instruction-class behavioural model.
module tb_ctrl_fsm;

   logic        clk = 1'b0;
   logic        reset, load, s;
   logic [15:0] instr;
   logic        w, write, vsel, loada, loadb, asel, bsel, loadc, loads, err;
   logic [2:0]  readnum, writenum;
   logic [1:0]  shift, ALUop;
   logic [15:0] sximm8, sximm5;

   int total = 0;
   int bad   = 0;

   ctrl_fsm dut (
      .clk(clk), .reset(reset), .load(load), .instr(instr), .s(s),
      .w(w), .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
      .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .loadc(loadc),
      .loads(loads), .shift(shift), .ALUop(ALUop), .sximm8(sximm8),
      .sximm5(sximm5), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] instr;
      int lat, nw, wnum, vsel, na, ra, nb, rb, nc, ns, asel, dflt, errs;
      logic [15:0] sx8, sx5;
      int sh, aop;
   } rec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Expected per-instruction behaviour, derived from the instruction class alone.
   function automatic rec_t exp_of(input logic [15:0] ins);
      rec_t e;
      logic [2:0] opc;
      logic [1:0] op;
      e = '{default: 0};
      e.instr = ins;
      opc = ins[15:13];
      op  = ins[12:11];
      e.sx8 = 16'($signed(ins[7:0]));
      e.sx5 = 16'($signed(ins[4:0]));
      e.sh  = int'(ins[4:3]);
      e.aop = int'(ins[12:11]);
      if (opc == 3'b110 && op == 2'b10) begin
         e.lat = 2; e.nw = 1; e.wnum = int'(ins[10:8]); e.vsel = 1;
      end else if (opc == 3'b110 && op == 2'b00) begin
         e.lat = 4; e.nw = 1; e.wnum = int'(ins[7:5]); e.nb = 1; e.rb = int'(ins[2:0]);
         e.nc = 1; e.asel = 1;
      end else if (opc == 3'b101) begin
         e.nb = 1; e.rb = int'(ins[2:0]);
         if (op != 2'b11) begin
            e.na = 1; e.ra = int'(ins[10:8]);
         end
         if (op == 2'b01) begin
            e.lat = 4; e.ns = 1;
         end else begin
            e.lat = (op == 2'b11) ? 4 : 5;
            e.nc = 1; e.nw = 1; e.wnum = int'(ins[7:5]);
         end
      end else begin
         e.lat = 1;  // illegal: DECODE then straight back to WAIT
      end
      return e;
   endfunction

   function automatic logic [15:0] rand_instr();
      logic [15:0] r;
      int k;
      r = 16'($urandom);
`ifdef CTRL_ILLEGAL_TRAP_EN
      k = $urandom_range(0, 5);
`else
      k = $urandom_range(0, 7);
`endif
      case (k)
         0:       r[15:11] = 5'b11010;
         1:       r[15:11] = 5'b11000;
         2, 3, 4: r[15:13] = 3'b101;
         5:       r[15:11] = 5'b10101;
         6:       r[15:13] = 3'b110;
         default: ;
      endcase
      return r;
   endfunction

   // Issue one instruction from WAIT and record strobe activity until w returns.
   task automatic run_instr(input logic [15:0] ins, output rec_t o);
      bit done;
      o = '{default: 0};
      o.instr = ins;
      instr = ins; load = 1'b1;
      step();
      load = 1'b0; s = 1'b1;
      step();
      s = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 12 && !done; c++) begin
         if (w) done = 1'b1;
         else begin
            if (write) begin o.nw++; o.wnum = int'(writenum); o.vsel = int'(vsel); end
            else if (writenum != 3'd0 || vsel) o.dflt++;
            if (loada) begin o.na++; o.ra = int'(readnum); end
            if (loadb) begin o.nb++; o.rb = int'(readnum); end
            if (!loada && !loadb && readnum != 3'd0) o.dflt++;
            if (loadc) o.nc++;
            if (loads) o.ns++;
            if (loadc || loads) o.asel = int'(asel);
            else if (asel) o.dflt++;
            if (bsel) o.dflt++;
            if (err) o.errs++;
            load  = 1'b1;
            instr = 16'($urandom);
            step();
            o.lat++;
         end
      end
      load = 1'b0;
      o.sx8 = sximm8;
      o.sx5 = sximm5;
      o.sh  = int'(shift);
      o.aop = int'(ALUop);
   endtask

   task automatic cmp(input rec_t a, input rec_t e, input string t);
      chk({t, ".lat"},  a.lat,  e.lat);
      chk({t, ".nw"},   a.nw,   e.nw);
      chk({t, ".wnum"}, a.wnum, e.wnum);
      chk({t, ".vsel"}, a.vsel, e.vsel);
      chk({t, ".na"},   a.na,   e.na);
      chk({t, ".ra"},   a.ra,   e.ra);
      chk({t, ".nb"},   a.nb,   e.nb);
      chk({t, ".rb"},   a.rb,   e.rb);
      chk({t, ".nc"},   a.nc,   e.nc);
      chk({t, ".ns"},   a.ns,   e.ns);
      chk({t, ".asel"}, a.asel, e.asel);
      chk({t, ".dflt"}, a.dflt, e.dflt);
      chk({t, ".err"},  a.errs, e.errs);
      chk({t, ".sx8"},  32'(a.sx8), 32'(e.sx8));
      chk({t, ".sx5"},  32'(a.sx5), 32'(e.sx5));
      chk({t, ".sh"},   a.sh,   e.sh);
      chk({t, ".aop"},  a.aop,  e.aop);
      $display("instr %h lat=%0d writes=%0d wnum=%0d", a.instr, a.lat, a.nw, a.wnum);
   endtask

   rec_t tv[7];
   rec_t obs;
   int   pat_w[6]  = '{0, 0, 1, 0, 0, 1};
   int   pat_wr[6] = '{0, 1, 0, 0, 1, 0};
   int   viol;

   initial begin
      tv[0] = '{16'hD0FD, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFD, 16'hFFFD, 3, 2};
      tv[1] = '{16'hA148, 5, 1, 2, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 16'h0048, 16'h0008, 1, 0};
      tv[2] = '{16'hA900, 4, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1};
      tv[3] = '{16'hC075, 4, 1, 3, 0, 0, 0, 1, 5, 1, 0, 1, 0, 0, 16'h0075, 16'hFFF5, 2, 0};
      tv[4] = '{16'hB8C2, 4, 1, 6, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 16'hFFC2, 16'h0002, 0, 3};
      tv[5] = '{16'hB4F9, 5, 1, 7, 0, 1, 4, 1, 1, 1, 0, 0, 0, 0, 16'hFFF9, 16'hFFF9, 3, 2};
      tv[6] = '{16'hD57F, 2, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h007F, 16'hFFFF, 3, 2};

      reset = 1'b1; load = 1'b0; s = 1'b0; instr = 16'h0000;
      step();
      chk("rst.w", 32'(w), 1);
      chk("rst.err", 32'(err), 0);
      chk("rst.strobes", 32'({write, loada, loadb, loadc, loads}), 0);
      chk("rst.sel", 32'({asel, bsel, vsel}), 0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("idle.w", 32'(w), 1);
      end

      for (int i = 0; i < 7; i++) begin
         run_instr(tv[i].instr, obs);
         cmp(obs, tv[i], $sformatf("vec%0d_%h", i, tv[i].instr));
      end

      // s held high: one WAIT cycle between back-to-back instructions
      instr = 16'hD0FD; load = 1'b1;
      step();
      load = 1'b0; s = 1'b1;
      for (int j = 0; j < 6; j++) begin
         step();
         chk($sformatf("b2b.w%0d", j), 32'(w), 32'(pat_w[j]));
         chk($sformatf("b2b.write%0d", j), 32'(write), 32'(pat_wr[j]));
      end
      s = 1'b0;
      step();
      $display("back-to-back MOV imm sequence done");

      // reset asserted while in GET_B
      instr = 16'hA148; load = 1'b1;
      step();
      load = 1'b0; s = 1'b1;
      step();
      s = 1'b0;
      chk("midrst.decode_w", 32'(w), 0);
      step();
      chk("midrst.loada", 32'(loada), 1);
      step();
      chk("midrst.loadb", 32'(loadb), 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst.w", 32'(w), 1);
      chk("midrst.write", 32'(write), 0);
      chk("midrst.ir", 32'(sximm8), 0);
      viol = 0;
      for (int j = 0; j < 4; j++) begin
         step();
         if (write || !w) viol++;
      end
      chk("midrst.after", viol, 0);
      $display("reset mid-instruction sequence done");

`ifdef CTRL_ILLEGAL_TRAP_EN
      instr = 16'hE000; load = 1'b1;
      step();
      load = 1'b0; s = 1'b1;
      step();
      s = 1'b0;
      step();
      chk("trap.err", 32'(err), 1);
      chk("trap.w", 32'(w), 0);
      viol = 0;
      for (int j = 0; j < 5; j++) begin
         s = 1'(j & 1); load = 1'b1; instr = 16'hD0FD;
         step();
         if (!err || w || write || loada || loadb || loadc || loads) viol++;
      end
      s = 1'b0; load = 1'b0;
      chk("trap.hold", viol, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("trap.rst_err", 32'(err), 0);
      chk("trap.rst_w", 32'(w), 1);
      $display("illegal instruction trap sequence done");
`else
      run_instr(16'hE000, obs);
      cmp(obs, exp_of(16'hE000), "illegal");
      step();
      chk("illegal.w2", 32'(w), 1);
      chk("illegal.err", 32'(err), 0);
`endif

      for (int i = 0; i < 40; i++) begin
         logic [15:0] ins;
         ins = rand_instr();
         run_instr(ins, obs);
         cmp(obs, exp_of(ins), $sformatf("rnd%0d_%h", i, ins));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
